// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Control vectors give the full output set for each decision the controller can make.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        MC_DONE = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic ctrl_sel;
        logic ifid_flush;
        logic exmem_bubble;
        logic mc_busy;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                       ctrl_sel: 1'b0, ifid_flush: 1'b0, exmem_bubble: 1'b0,
                                       mc_busy: 1'b0};
    localparam ctrl_t CTRL_RESET   = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                       ctrl_sel: 1'b1, ifid_flush: 1'b0, exmem_bubble: 1'b1,
                                       mc_busy: 1'b0};
    localparam ctrl_t CTRL_MC_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                        ctrl_sel: 1'b0, ifid_flush: 1'b0, exmem_bubble: 1'b1,
                                        mc_busy: 1'b1};
    localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b1,
                                        ctrl_sel: 1'b1, ifid_flush: 1'b0, exmem_bubble: 1'b0,
                                        mc_busy: 1'b0};
    localparam ctrl_t CTRL_BRANCH  = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                       ctrl_sel: 1'b1, ifid_flush: 1'b1, exmem_bubble: 1'b0,
                                       mc_busy: 1'b0};

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-unit bundle: pipeline status from ID/EX in, stall/flush controls out.
interface hazard_stall_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic [REG_W-1:0] EX_Rt;
    logic             EX_BranchTaken;
    logic             EX_McStart;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXWrite;
    logic             CtrlSel;
    logic             EXMEMBubble;
    logic             McBusy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rt, EX_BranchTaken, EX_McStart,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, CtrlSel, EXMEMBubble, McBusy, StallCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rt, EX_BranchTaken, EX_McStart,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, CtrlSel, EXMEMBubble, McBusy, StallCount
    );
endinterface

// File: rtl/hazard_stall_ctrl_mc_counter.sv
// Loadable down-counter tracking remaining multi-cycle EX occupancy.
// o_term flags the last wait cycle (count == 1).
module mc_latency_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_term
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_term = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use stall, taken-branch flush, multi-cycle EX hold,
// plus a saturating count of PC-stalled cycles. Outputs are Mealy (zero latency).
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic          Clk,
    input logic          Reset_n,
    hazard_stall_ctrl_if.slave bus
);
    localparam int unsigned MC_W = $clog2(MC_LAT);
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LAT - 2);

    state_e           r_state;
    state_e           w_state_d;
    ctrl_t            w_ctrl;
    logic             w_load_use;
    logic             w_mc_load;
    logic             w_mc_dec;
    logic             w_mc_term;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_load_use = bus.EX_MemRead && (bus.EX_Rt != REG_W'(REG_ZERO)) &&
                        ((bus.ID_Rs == bus.EX_Rt) ||
                         (bus.ID_UsesRt && (bus.ID_Rt == bus.EX_Rt)));

    always_comb begin
        w_ctrl    = CTRL_DEFAULT;
        w_state_d = r_state;
        w_mc_load = 1'b0;
        w_mc_dec  = 1'b0;
        if (!Reset_n) begin
            w_ctrl    = CTRL_RESET;
            w_state_d = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.EX_BranchTaken) begin
                        w_ctrl = CTRL_BRANCH;
                    end else if (bus.EX_McStart) begin
                        w_ctrl    = CTRL_MC_STALL;
                        w_mc_load = 1'b1;
                        w_state_d = (MC_LAT == 2) ? MC_DONE : MC_WAIT;
                    end else if (w_load_use) begin
                        w_ctrl = CTRL_LOAD_USE;
                    end
                end
                MC_WAIT: begin
                    w_ctrl   = CTRL_MC_STALL;
                    w_mc_dec = 1'b1;
                    if (w_mc_term) w_state_d = MC_DONE;
                end
                MC_DONE: begin
                    // The finishing op is still in ID/EX, so its McStart is not a new request.
                    if (bus.EX_BranchTaken) begin
                        w_ctrl = CTRL_BRANCH;
                    end else if (w_load_use) begin
                        w_ctrl = CTRL_LOAD_USE;
                    end
                    w_state_d = RUN;
                end
                default: w_state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_cnt <= '0;
        end else if (!w_ctrl.pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    mc_latency_counter #(
        .CNT_W (MC_W)
    ) u_mc_cnt (
        .i_clk      (Clk),
        .i_rst_n    (Reset_n),
        .i_load     (w_mc_load),
        .i_load_val (MC_LOAD),
        .i_dec      (w_mc_dec),
        .o_term     (w_mc_term)
    );

    assign bus.PCWrite     = w_ctrl.pc_write;
    assign bus.IFIDWrite   = w_ctrl.ifid_write;
    assign bus.IDEXWrite   = w_ctrl.idex_write;
    assign bus.CtrlSel     = w_ctrl.ctrl_sel;
    assign bus.IFIDFlush   = w_ctrl.ifid_flush;
    assign bus.EXMEMBubble = w_ctrl.exmem_bubble;
    assign bus.McBusy      = w_ctrl.mc_busy;
    assign bus.StallCount  = r_stall_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: MC_LAT=4 and MC_LAT=2 instances, expected outputs queued
// per driven cycle and compared at the following falling edge.
module tb_hazard_stall_ctrl;

    // Output vector order: PCWrite IFIDWrite IDEXWrite CtrlSel IFIDFlush EXMEMBubble McBusy
    localparam logic [6:0] E_DEF = 7'b1110000;
    localparam logic [6:0] E_RST = 7'b0001010;
    localparam logic [6:0] E_MC  = 7'b0000011;
    localparam logic [6:0] E_LU  = 7'b0011000;
    localparam logic [6:0] E_BR  = 7'b1111100;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mr;
        logic [4:0] exrt;
        logic       br;
        logic       mc;
        logic [6:0] exp;
    } row_t;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_cnt4 = 16'h0;
    logic [15:0] exp_cnt2 = 16'h0;
    exp_t sb4[$];
    exp_t sb2[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) if4 ();
    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) if2 ();

    hazard_stall_ctrl #(.REG_W(5), .MC_LAT(4), .CNT_W(16)) dut4 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (if4)
    );

    hazard_stall_ctrl #(.REG_W(5), .MC_LAT(2), .CNT_W(16)) dut2 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (if2)
    );

    function automatic logic [6:0] obs(input int which);
        if (which == 0)
            return {if4.PCWrite, if4.IFIDWrite, if4.IDEXWrite, if4.CtrlSel, if4.IFIDFlush,
                    if4.EXMEMBubble, if4.McBusy};
        return {if2.PCWrite, if2.IFIDWrite, if2.IDEXWrite, if2.CtrlSel, if2.IFIDFlush,
                if2.EXMEMBubble, if2.McBusy};
    endfunction

    function automatic row_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                input logic mr, input logic [4:0] exrt, input logic br,
                                input logic mc, input logic [6:0] exp);
        row_t r;
        r.rs = rs; r.rt = rt; r.uses = uses; r.mr = mr; r.exrt = exrt;
        r.br = br; r.mc = mc; r.exp = exp;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and queue the expected outputs for that cycle.
    task automatic apply(input int which, input row_t r);
        exp_t e;
        e.ctrl = r.exp;
        if (which == 0) begin
            if4.ID_Rs = r.rs; if4.ID_Rt = r.rt; if4.ID_UsesRt = r.uses;
            if4.EX_MemRead = r.mr; if4.EX_Rt = r.exrt;
            if4.EX_BranchTaken = r.br; if4.EX_McStart = r.mc;
            e.cnt = exp_cnt4;
            sb4.push_back(e);
            if (!r.exp[6] && exp_cnt4 != 16'hFFFF) exp_cnt4 = exp_cnt4 + 16'd1;
        end else begin
            if2.ID_Rs = r.rs; if2.ID_Rt = r.rt; if2.ID_UsesRt = r.uses;
            if2.EX_MemRead = r.mr; if2.EX_Rt = r.exrt;
            if2.EX_BranchTaken = r.br; if2.EX_McStart = r.mc;
            e.cnt = exp_cnt2;
            sb2.push_back(e);
            if (!r.exp[6] && exp_cnt2 != 16'hFFFF) exp_cnt2 = exp_cnt2 + 16'd1;
        end
    endtask

    task automatic test_reset();
        row_t idle;
        exp_t e;
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_DEF);
        apply(1, idle);
        void'(sb2.pop_front());
        apply(0, idle);
        void'(sb4.pop_front());
        exp_cnt4 = 16'h0;
        exp_cnt2 = 16'h0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if (obs(w) !== E_RST || (w == 0 ? if4.StallCount : if2.StallCount) !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_held[dut%0d]: ctrl=%b cnt=%h, expected ctrl=%b cnt=0000",
                         w, obs(w), (w == 0 ? if4.StallCount : if2.StallCount), E_RST);
            end
        end
        next_cycle();
        rst_n = 1'b1;
        apply(0, idle);
        @(negedge clk);
        e = sb4.pop_front();
        n_checks++;
        if (obs(0) !== e.ctrl || if4.StallCount !== e.cnt) begin
            n_fail++;
            $display("FAIL reset_release: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                     obs(0), if4.StallCount, e.ctrl, e.cnt);
        end
    endtask

    task automatic test_load_use();
        row_t rows[7];
        exp_t e;
        rows[0] = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, E_LU);
        rows[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_DEF);
        rows[2] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, E_DEF);
        rows[3] = mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, E_LU);
        rows[4] = mk(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, E_DEF);
        rows[5] = mk(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, E_DEF);
        rows[6] = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, E_DEF);
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            apply(0, rows[i]);
            @(negedge clk);
            e = sb4.pop_front();
            n_checks++;
            if (obs(0) !== e.ctrl || if4.StallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL load_use[%0d]: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                         i, obs(0), if4.StallCount, e.ctrl, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        row_t rows[6];
        exp_t e;
        rows[0] = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, E_BR);
        rows[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_BR);
        rows[2] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_DEF);
        rows[3] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR);
        rows[4] = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, E_LU);
        rows[5] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_DEF);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            apply(0, rows[i]);
            @(negedge clk);
            e = sb4.pop_front();
            n_checks++;
            if (obs(0) !== e.ctrl || if4.StallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL branch[%0d]: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                         i, obs(0), if4.StallCount, e.ctrl, e.cnt);
            end
        end
    endtask

    task automatic test_multicycle_lat4();
        row_t rows[15];
        row_t mc, mclu, mcbr, idle;
        exp_t e;
        mc   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_MC);
        mclu = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, E_MC);
        mcbr = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_MC);
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_DEF);
        rows[0] = mc;  rows[1] = mclu; rows[2] = mcbr;
        rows[3] = mc;  rows[3].exp = E_DEF;
        rows[4] = idle;
        rows[5] = mc;  rows[6] = mc;   rows[7] = mc;
        rows[8] = mclu; rows[8].exp = E_LU;
        rows[9] = idle;
        rows[10] = mc; rows[11] = mc;  rows[12] = mc;
        rows[13] = mcbr; rows[13].exp = E_BR;
        rows[14] = idle;
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            apply(0, rows[i]);
            @(negedge clk);
            e = sb4.pop_front();
            n_checks++;
            if (obs(0) !== e.ctrl || if4.StallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL mc_lat4[%0d]: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                         i, obs(0), if4.StallCount, e.ctrl, e.cnt);
            end
        end
    endtask

    task automatic test_multicycle_lat2();
        row_t rows[9];
        row_t mc, idle;
        exp_t e;
        mc   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_MC);
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_DEF);
        rows[0] = mc;
        rows[1] = mc; rows[1].exp = E_DEF;
        rows[2] = idle;
        rows[3] = mc;
        rows[4] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_BR);
        rows[5] = idle;
        rows[6] = mc;
        rows[7] = mk(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, E_LU);
        rows[8] = idle;
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            apply(1, rows[i]);
            @(negedge clk);
            e = sb2.pop_front();
            n_checks++;
            if (obs(1) !== e.ctrl || if2.StallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL mc_lat2[%0d]: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                         i, obs(1), if2.StallCount, e.ctrl, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_mc();
        row_t mc, idle;
        exp_t e;
        mc   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_MC);
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_DEF);
        // RUN start, then the 1st and 2nd MC_WAIT cycles
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            apply(0, mc);
            @(negedge clk);
            e = sb4.pop_front();
            n_checks++;
            if (obs(0) !== e.ctrl || if4.StallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL mid_mc_pre[%0d]: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                         i, obs(0), if4.StallCount, e.ctrl, e.cnt);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs(0) !== E_RST || if4.StallCount !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_mc_reset: ctrl=%b cnt=%h, expected ctrl=%b cnt=0000",
                     obs(0), if4.StallCount, E_RST);
        end
        next_cycle();
        rst_n = 1'b1;
        exp_cnt4 = 16'h0;
        exp_cnt2 = 16'h0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) next_cycle();
            apply(0, idle);
            @(negedge clk);
            e = sb4.pop_front();
            n_checks++;
            if (obs(0) !== e.ctrl || if4.StallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL mid_mc_post[%0d]: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                         i, obs(0), if4.StallCount, e.ctrl, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        row_t lu, idle;
        exp_t e;
        lu   = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, E_LU);
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_DEF);
        for (int i = 0; i < 65540; i++) begin
            next_cycle();
            apply(0, lu);
            @(negedge clk);
            e = sb4.pop_front();
            n_checks++;
            if (obs(0) !== e.ctrl || if4.StallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL saturate[%0d]: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                         i, obs(0), if4.StallCount, e.ctrl, e.cnt);
            end
        end
        next_cycle();
        apply(0, idle);
        @(negedge clk);
        e = sb4.pop_front();
        n_checks++;
        if (obs(0) !== e.ctrl || if4.StallCount !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturate_final: ctrl=%b cnt=%h, expected ctrl=%b cnt=ffff",
                     obs(0), if4.StallCount, e.ctrl);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_multicycle_lat4();
        test_multicycle_lat2();
        test_reset_mid_mc();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
